calc_op_sequencer: RTL

- Front-end controller for the 4-bit signed calculator ALU: add, subtract and absolute value, with two hex digits for the result and "E" on overflow.
- Turns debounced DE2 push-button presses plus switch values into one sequenced operation:
  - latch A;
  - latch B and op;
  - drive the combinational ALU;
  - wait a settle window;
  - capture result and overflow.
- Supports chaining, where the last result becomes the next A.
- Sits between the board I/O (KEY/SW) and the existing combinational calculator datapath, which stays unchanged.

---
 rtl/calc_op_sequencer.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/calc_op_sequencer.sv
// Front-end sequencer for the 4-bit signed calculator: debounces KEY presses and
// steps the external combinational ALU through latch A, latch B/op, settle, capture.
module calc_op_sequencer #(
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int SETTLE_CYCLES   = 2
) (
    input  logic       CLOCK_50,
    input  logic       reset,
    input  logic [1:0] KEY_n,
    input  logic [3:0] sw_val,
    input  logic [2:0] sw_op,
    input  logic [3:0] alu_r,
    input  logic       alu_ovf,
    output logic [3:0] alu_a,
    output logic [3:0] alu_b,
    output logic [2:0] alu_op,
    output logic [3:0] result_q,
    output logic       ovf_q,
    output logic       ovf_sticky,
    output logic       valid,
    output logic       busy,
    output logic [7:0] op_count,
    output logic [2:0] state
);

    localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int SW = $clog2(SETTLE_CYCLES + 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        GET_B = 3'd1,
        EXEC  = 3'd2,
        DONE  = 3'd3
    } state_t;

    logic [1:0]    key_meta;
    logic [1:0]    key_sync;
    logic [1:0]    key_level;
    logic [1:0]    key_pulse;
    logic [DW-1:0] db_cnt [2];

    // key_level is the accepted (debounced) level; 1 means released.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            key_meta  <= '1;
            key_sync  <= '1;
            key_level <= '1;
            key_pulse <= '0;
            for (int i = 0; i < 2; i++) db_cnt[i] <= '0;
        end else begin
            key_meta  <= KEY_n;
            key_sync  <= key_meta;
            key_pulse <= '0;
            for (int i = 0; i < 2; i++) begin
                if (key_sync[i] == key_level[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == DW'(DEBOUNCE_CYCLES - 1)) begin
                    key_level[i] <= key_sync[i];
                    db_cnt[i]    <= '0;
                    key_pulse[i] <= ~key_sync[i];
                end else begin
                    db_cnt[i] <= db_cnt[i] + 1'b1;
                end
            end
        end
    end

    logic          enter_p;
    logic          chain_p;
    state_t        state_q;
    state_t        state_d;
    logic [SW-1:0] settle_cnt;
    logic          ld_a_sw;
    logic          ld_a_res;
    logic          ld_b;
    logic          capture;

    assign enter_p = key_pulse[0];
    assign chain_p = key_pulse[1];

    always_ff @(posedge CLOCK_50) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // NOTE: every signal written here gets a default first, so no latches are inferred.
    always_comb begin
        state_d  = state_q;
        ld_a_sw  = 1'b0;
        ld_a_res = 1'b0;
        ld_b     = 1'b0;
        capture  = 1'b0;
        case (state_q)
            IDLE: if (enter_p) begin
                ld_a_sw = 1'b1;
                state_d = GET_B;
            end
            GET_B: if (enter_p) begin
                ld_b    = 1'b1;
                state_d = EXEC;
            end
            EXEC: if (settle_cnt == SW'(1)) begin
                capture = 1'b1;
                state_d = DONE;
            end
            DONE: if (enter_p) begin
                ld_a_sw = 1'b1;
                state_d = GET_B;
            end else if (chain_p && !ovf_q) begin
                ld_a_res = 1'b1;
                state_d  = GET_B;
            end
            default: state_d = IDLE;
        endcase
    end

    // Operands only move on latch events; a chained A is result_q bit-exact.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            alu_a      <= '0;
            alu_b      <= '0;
            alu_op     <= '0;
            result_q   <= '0;
            ovf_q      <= 1'b0;
            ovf_sticky <= 1'b0;
            valid      <= 1'b0;
            op_count   <= '0;
            settle_cnt <= '0;
        end else begin
            if (ld_a_sw)       alu_a <= sw_val;
            else if (ld_a_res) alu_a <= result_q;

            if (ld_b) begin
                alu_b      <= sw_val;
                alu_op     <= sw_op;
                settle_cnt <= SW'(SETTLE_CYCLES);
            end else if (state_q == EXEC) begin
                settle_cnt <= settle_cnt - 1'b1;
            end

            if (capture) begin
                result_q   <= alu_r;
                ovf_q      <= alu_ovf;
                ovf_sticky <= ovf_sticky | alu_ovf;
                valid      <= 1'b1;
                if (op_count != 8'hFF) op_count <= op_count + 1'b1;
            end else if (ld_a_sw || ld_a_res) begin
                valid <= 1'b0;
            end
        end
    end

    assign busy  = (state_q == EXEC);
    assign state = state_q;

endmodule
